// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: rotate, logical and arithmetic shifts in either direction.
// One pipeline stage per shift level (2^k), valid/ready handshake with lossless backpressure.
// Optional build macro BARREL_SHIFT_FLAGS_EN adds out_zero / out_carry result flags.
module barrel_shift_pipe #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shift,
  input  logic             in_right,
  input  logic [1:0]       in_mode,
`ifdef BARREL_SHIFT_FLAGS_EN
  output logic             out_zero,
  output logic             out_carry,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // One shift level of 2^level. Left rotates index backwards directly, so no amount negation.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] d,
                                                   input int unsigned   level,
                                                   input logic          en,
                                                   input logic          right,
                                                   input logic [1:0]    mode,
                                                   input logic          sign);
    logic [WIDTH-1:0] r;
    logic [SW-1:0]    src;
    logic [SW-1:0]    dst;
    logic             rot;
    logic             fill;
    logic             wrapped;
    int unsigned      s;
    s    = 32'd1 << level;
    rot  = (mode == 2'b00) || (mode == 2'b11);
    fill = right && (mode == 2'b10) && sign;
    r    = d;
    if (en) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        dst     = SW'(i);
        // Source index wraps modulo WIDTH; wrapped bits are either rotated in or filled.
        src     = right ? SW'(i + s) : SW'(i - s);
        wrapped = right ? (i + s >= WIDTH) : (i < s);
        r[dst]  = (wrapped && !rot) ? fill : d[src];
      end
    end
    return r;
  endfunction

`ifdef BARREL_SHIFT_FLAGS_EN
  logic          in_carry;
  logic [SW-1:0] neg_shift;
  logic          in_rot;

  assign neg_shift = -in_shift;
  assign in_rot    = (in_mode == 2'b00) || (in_mode == 2'b11);

  // Last bit shifted out, taken straight from the operand at the input stage.
  always_comb begin
    in_carry = 1'b0;
    if (!in_rot && (in_shift != '0)) begin
      in_carry = in_right ? in_data[in_shift - SW'(1)] : in_data[neg_shift];
    end
  end
`endif

  for (genvar k = 0; k < SW; k++) begin : g_stage
    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SW-1:0]    amt_q;
    logic             right_q;
    logic [1:0]       mode_q;
    logic             sign_q;

    logic             valid_d;
    logic [WIDTH-1:0] src_data;
    logic [WIDTH-1:0] data_d;
    logic [SW-1:0]    amt_d;
    logic             right_d;
    logic [1:0]       mode_d;
    logic             sign_d;

    logic             load;
    logic             adv;
    logic             unused_stage;

    if (k == 0) begin : g_head
      assign valid_d  = in_valid;
      assign src_data = in_data;
      assign amt_d    = in_shift;
      assign right_d  = in_right;
      assign mode_d   = in_mode;
      assign sign_d   = in_data[WIDTH-1];
    end else begin : g_body
      assign valid_d  = g_stage[k-1].valid_q;
      assign src_data = g_stage[k-1].data_q;
      assign amt_d    = g_stage[k-1].amt_q;
      assign right_d  = g_stage[k-1].right_q;
      assign mode_d   = g_stage[k-1].mode_q;
      assign sign_d   = g_stage[k-1].sign_q;
    end

    assign data_d = shift_level(src_data, k, amt_d[k], right_d, mode_d, sign_d);

    // Load when empty or when the contents move on; the tail moves on when the consumer takes it.
    if (k == SW - 1) begin : g_tail
      assign adv = out_ready || !valid_q;
    end else begin : g_mid
      assign adv = g_stage[k+1].load;
    end
    assign load = !valid_q || adv;

    // Stage register; payload only updates on a valid load so a stalled tail holds steady.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        amt_q   <= '0;
        right_q <= 1'b0;
        mode_q  <= '0;
        sign_q  <= 1'b0;
      end else if (load) begin
        valid_q <= valid_d;
        if (valid_d) begin
          data_q  <= data_d;
          amt_q   <= amt_d;
          right_q <= right_d;
          mode_q  <= mode_d;
          sign_q  <= sign_d;
        end
      end
    end

    // Amount bits below k and the tail's control fields are not consumed downstream.
    assign unused_stage = ^{amt_q, right_q, mode_q, sign_q};

`ifdef BARREL_SHIFT_FLAGS_EN
    logic carry_q;
    logic carry_d;

    if (k == 0) begin : g_carry_head
      assign carry_d = in_carry;
    end else begin : g_carry_body
      assign carry_d = g_stage[k-1].carry_q;
    end

    // Carry flag travels alongside the data.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        carry_q <= 1'b0;
      end else if (load && valid_d) begin
        carry_q <= carry_d;
      end
    end
`endif
  end

  assign in_ready  = g_stage[0].load;
  assign out_valid = g_stage[SW-1].valid_q;
  assign out_data  = g_stage[SW-1].data_q;

`ifdef BARREL_SHIFT_FLAGS_EN
  assign out_zero  = out_valid && (out_data == '0);
  assign out_carry = out_valid && g_stage[SW-1].carry_q;
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed bench for barrel_shift_pipe (WIDTH=32): shift/rotate vectors, backpressure, reset.
module tb_barrel_shift_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SW    = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SW-1:0]    in_shift;
  logic             in_right;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef BARREL_SHIFT_FLAGS_EN
  logic             out_zero;
  logic             out_carry;
`endif

  int checks = 0;
  int errors = 0;

  barrel_shift_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_right  (in_right),
    .in_mode   (in_mode),
`ifdef BARREL_SHIFT_FLAGS_EN
    .out_zero  (out_zero),
    .out_carry (out_carry),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference built from wide shifts, independent of the per-level structure.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] n,
                                            input logic right, input logic [1:0] mode);
    logic [63:0] dd;
    logic [31:0] r;
    dd = {d, d};
    if (mode == 2'b00 || mode == 2'b11) begin
      if (right) begin
        dd = dd >> n;
        r  = dd[31:0];
      end else begin
        dd = dd << n;
        r  = dd[63:32];
      end
    end else if (right && mode == 2'b10) begin
      r = $signed(d) >>> n;
    end else if (right) begin
      r = d >> n;
    end else begin
      r = d << n;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation through an empty pipeline with out_ready=1; checks latency, data, flags.
  task automatic run_one(input string tag, input logic [31:0] d, input logic [4:0] n,
                         input logic right, input logic [1:0] mode,
                         input logic [31:0] exp, input logic exp_carry);
    int lat;
    in_valid = 1'b1;
    in_data  = d;
    in_shift = n;
    in_right = right;
    in_mode  = mode;
    #1;
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, 32'd5);
    check(tag, out_data, exp);
`ifdef BARREL_SHIFT_FLAGS_EN
    check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, exp == 32'd0});
    check({tag, "_carry"}, {31'd0, out_carry}, {31'd0, exp_carry});
`else
    if (exp_carry === 1'bx) $display("unexpected x carry");
`endif
    step();
  endtask

  logic [31:0] bd [20];
  logic [4:0]  bn [20];
  logic        br [20];
  logic [1:0]  bm [20];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    in_right  = 1'b0;
    in_mode   = '0;
    out_ready = 1'b1;
    repeat (3) step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_idle_valid", {31'd0, out_valid}, 32'd0);

    run_one("ror1", 32'h8000_0001, 5'd1, 1'b1, 2'b00, 32'hC000_0000, 1'b0);
    run_one("rol4", 32'h8000_0001, 5'd4, 1'b0, 2'b00, 32'h0000_0018, 1'b0);
    run_one("asr31", 32'h8000_0000, 5'd31, 1'b1, 2'b10, 32'hFFFF_FFFF, 1'b0);
    run_one("lsr31", 32'h8000_0000, 5'd31, 1'b1, 2'b01, 32'h0000_0001, 1'b0);
    run_one("asr31p", 32'h7FFF_FFFF, 5'd31, 1'b1, 2'b10, 32'h0000_0000, 1'b1);
    run_one("lsl16", 32'h0000_FFFF, 5'd16, 1'b0, 2'b01, 32'hFFFF_0000, 1'b0);
    run_one("ror8_m3", 32'h1234_5678, 5'd8, 1'b1, 2'b11, 32'h7812_3456, 1'b0);
    run_one("asl1", 32'h8000_0001, 5'd1, 1'b0, 2'b10, 32'h0000_0002, 1'b1);
    run_one("asr4p", 32'h4000_0000, 5'd4, 1'b1, 2'b10, 32'h0400_0000, 1'b0);
    run_one("lsr2_flag", 32'h0000_0003, 5'd2, 1'b1, 2'b01, 32'h0000_0000, 1'b1);
    run_one("ror2_flag", 32'h0000_0003, 5'd2, 1'b1, 2'b00, 32'hC000_0000, 1'b0);
    for (int m = 0; m < 4; m++) begin
      for (int r = 0; r < 2; r++) begin
        run_one("zero_amt", 32'hDEAD_BEEF, 5'd0, r[0], m[1:0], 32'hDEAD_BEEF, 1'b0);
      end
    end

    // Backpressure: 20 ops back to back, consumer stalled for cycles 3..12.
    begin
      logic [31:0] q [$];
      int sent = 0;
      int got = 0;
      int cyc = 0;
      int acc_at_drop = -1;
      for (int i = 0; i < 20; i++) begin
        bd[i] = $urandom;
        bn[i] = 5'($urandom_range(0, 31));
        br[i] = 1'($urandom_range(0, 1));
        bm[i] = 2'($urandom_range(0, 3));
      end
      while (got < 20 && cyc < 200) begin
        out_ready = !(cyc >= 3 && cyc <= 12);
        in_valid  = (sent < 20);
        if (sent < 20) begin
          in_data  = bd[sent];
          in_shift = bn[sent];
          in_right = br[sent];
          in_mode  = bm[sent];
        end
        #1;
        if (in_valid && !in_ready && acc_at_drop < 0) acc_at_drop = sent;
        if (cyc >= 13) check("bp_nogap", {31'd0, out_valid}, 32'd1);
        if (out_valid) begin
          if (q.size() == 0) begin
            check("bp_spurious", {31'd0, out_valid}, 32'd0);
          end else if (out_ready) begin
            check("bp_data", out_data, q.pop_front());
            got++;
          end else begin
            check("bp_hold", out_data, q[0]);
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(ref_shift(bd[sent], bn[sent], br[sent], bm[sent]));
          sent++;
        end
        step();
        cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_count", got, 32'd20);
      check("bp_full_accepts", acc_at_drop, 32'd5);
      step();
      check("bp_empty", {31'd0, out_valid}, 32'd0);
    end

    // Reset with three operations in flight.
    begin
      int seen = 0;
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1;
        in_data  = 32'hA5A5_0000 | 32'(i);
        in_shift = 5'(i + 1);
        in_right = 1'b1;
        in_mode  = 2'b00;
        #1;
        check("mid_rdy", {31'd0, in_ready}, 32'd1);
        step();
      end
      in_valid = 1'b0;
      step();
      step();
      check("mid_pre_valid", {31'd0, out_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_data", out_data, 32'd0);
      repeat (2) step();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 20; i++) begin
        if (out_valid) seen++;
        step();
      end
      check("mid_ghosts", seen, 32'd0);
      run_one("post_rst", 32'h0000_00F0, 5'd4, 1'b0, 2'b01, 32'h0000_0F00, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
